// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash emulator: serves READ (0x03) from a byte-wide memory port with one-byte prefetch.
// Define SPI_FLASH_RESP_FAST_READ_EN to also accept FAST_READ (0x0B) with 8 dummy clocks.
module spi_flash_responder #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flash_csb,
  input  logic              flash_clk,
  input  logic              flash_io0,
  output logic              flash_io1,
  output logic              flash_io1_oe,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              underrun
);

  localparam logic [24:0]       MEM_SZ   = 25'(MEM_BYTES);
  localparam logic [ADDR_W-1:0] MEM_LAST = ADDR_W'(MEM_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } state_t;

  logic csb_meta_q, csb_sync_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic io0_meta_q, io0_sync_q;

  state_t            state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [22:0]       shift_q, shift_d;
  logic              fast_q, fast_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        out_sh_q, out_sh_d;
  logic              io1_q, io1_d;
  logic              oe_q, oe_d;
  logic [7:0]        buf_q, buf_d;
  logic              buf_vld_q, buf_vld_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              pend_q, pend_d;
  logic              drop_q, drop_d;
  logic              underrun_q, underrun_d;

  logic              sclk_rise, sclk_fall, mem_done, fetch_req;
  logic [23:0]       shift_in;
  logic [ADDR_W-1:0] addr_rx, addr_inc, fetch_addr;
  logic [7:0]        load_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      csb_meta_q  <= 1'b1;
      csb_sync_q  <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      io0_meta_q  <= 1'b0;
      io0_sync_q  <= 1'b0;
    end else begin
      csb_meta_q  <= flash_csb;
      csb_sync_q  <= csb_meta_q;
      sclk_meta_q <= flash_clk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      io0_meta_q  <= flash_io0;
      io0_sync_q  <= io0_meta_q;
    end
  end

  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
  assign mem_done  = mem_valid_q & mem_ready;
  assign shift_in  = {shift_q, io0_sync_q};
  assign addr_rx   = ADDR_W'(25'(shift_in[ADDR_W-1:0]) % MEM_SZ);
  assign addr_inc  = (addr_q == MEM_LAST) ? '0 : addr_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    fast_d      = fast_q;
    addr_d      = addr_q;
    out_sh_d    = out_sh_q;
    io1_d       = io1_q;
    oe_d        = oe_q;
    buf_d       = buf_q;
    buf_vld_d   = buf_vld_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    pend_d      = pend_q;
    drop_d      = drop_q;
    underrun_d  = underrun_q;
    fetch_req   = 1'b0;
    fetch_addr  = addr_q;
    load_byte   = 8'hFF;

    // A fetch that was outstanding when its byte was abandoned completes with drop_q set and is discarded.
    if (mem_done) begin
      mem_valid_d = 1'b0;
      drop_d      = 1'b0;
      if (!drop_q) begin
        buf_d     = mem_rdata;
        buf_vld_d = 1'b1;
      end
    end else if (!mem_valid_q && pend_q) begin
      mem_valid_d = 1'b1;
      mem_addr_d  = addr_q;
      pend_d      = 1'b0;
    end

    if (csb_sync_q) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      io1_d     = 1'b1;
      buf_vld_d = 1'b0;
      pend_d    = 1'b0;
      if (mem_valid_q && !mem_done) drop_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
        end
        ST_CMD: if (sclk_rise) begin
          shift_d   = shift_in[22:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            state_d   = ST_IGNORE;
            fast_d    = 1'b0;
            if (shift_in[7:0] == 8'h03) state_d = ST_ADDR;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
            else if (shift_in[7:0] == 8'h0B) begin
              state_d = ST_ADDR;
              fast_d  = 1'b1;
            end
`endif
          end
        end
        ST_ADDR: if (sclk_rise) begin
          shift_d   = shift_in[22:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d  = '0;
            addr_d     = addr_rx;
            fetch_req  = 1'b1;
            fetch_addr = addr_rx;
            state_d    = fast_q ? ST_DUMMY : ST_DATA;
          end
        end
        ST_DUMMY: if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            state_d   = ST_DATA;
          end
        end
        ST_DATA: if (sclk_fall) begin
          oe_d = 1'b1;
          if (bit_cnt_q == 5'd0) begin
            // Byte boundary: take the prefetched byte (or one arriving this cycle), else underrun.
            if (buf_vld_q) begin
              load_byte = buf_q;
              buf_vld_d = 1'b0;
            end else if (mem_done && !drop_q) begin
              load_byte = mem_rdata;
              buf_vld_d = 1'b0;
            end else begin
              load_byte  = 8'hFF;
              underrun_d = 1'b1;
              if (mem_valid_q && !mem_done) drop_d = 1'b1;
            end
            io1_d      = load_byte[7];
            out_sh_d   = {load_byte[6:0], 1'b1};
            bit_cnt_d  = 5'd7;
            addr_d     = addr_inc;
            fetch_req  = 1'b1;
            fetch_addr = addr_inc;
          end else begin
            io1_d     = out_sh_q[7];
            out_sh_d  = {out_sh_q[6:0], 1'b1};
            bit_cnt_d = bit_cnt_q - 5'd1;
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end

    if (fetch_req) begin
      if (!mem_valid_q) begin
        mem_valid_d = 1'b1;
        mem_addr_d  = fetch_addr;
        pend_d      = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      fast_q      <= 1'b0;
      addr_q      <= '0;
      out_sh_q    <= '1;
      io1_q       <= 1'b1;
      oe_q        <= 1'b0;
      buf_q       <= '0;
      buf_vld_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      pend_q      <= 1'b0;
      drop_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      fast_q      <= fast_d;
      addr_q      <= addr_d;
      out_sh_q    <= out_sh_d;
      io1_q       <= io1_d;
      oe_q        <= oe_d;
      buf_q       <= buf_d;
      buf_vld_q   <= buf_vld_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      pend_q      <= pend_d;
      drop_q      <= drop_d;
      underrun_q  <= underrun_d;
    end
  end

  assign flash_io1    = io1_q;
  assign flash_io1_oe = oe_q;
  assign mem_valid    = mem_valid_q;
  assign mem_addr     = mem_addr_q;
  assign busy         = ~csb_sync_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed, table-driven bench for spi_flash_responder: SPI master model plus latency-programmable memory.
module tb_spi_flash_responder;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        reset, flash_csb, flash_clk, flash_io0;
  logic        flash_io1, flash_io1_oe, mem_valid, mem_ready, busy, underrun;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata;

  spi_flash_responder #(.ADDR_W(24), .MEM_BYTES(65536)) dut (
    .clk(clk), .reset(reset),
    .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0(flash_io0),
    .flash_io1(flash_io1), .flash_io1_oe(flash_io1_oe),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  logic [15:0] fetch_log[$];
  logic        slow_en = 1'b0;
  logic [15:0] slow_addr = 16'h0;
  int          wait_cnt = 0;
  int          oe_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // Memory responder: answers after 1 cycle, or 480 cycles for the programmed slow address.
  always @(negedge clk) begin
    if (reset) begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end else if (mem_valid) begin
      if (wait_cnt >= ((slow_en && mem_addr[15:0] == slow_addr) ? 480 : 1)) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[15:0]];
      end else begin
        wait_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && mem_valid && mem_ready) fetch_log.push_back(mem_addr[15:0]);
    if (flash_io1_oe) oe_cnt <= oe_cnt + 1;
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          ndummy;
    int          nbytes;
    logic [31:0] exp_bytes;
    logic        exp_oe;
    int          nfetch;
    logic [79:0] fetches;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCLK period; with last set, csb rises in the same instant as the final fall.
  task automatic spi_bit(input logic din, input logic last, output logic dout);
    flash_io0 = din;
    tick(HALF);
    dout = flash_io1;
    flash_clk = 1'b1;
    tick(HALF);
    flash_clk = 1'b0;
    if (last) flash_csb = 1'b1;
  endtask

  task automatic wait_mem_idle(input string tag);
    int k = 0;
    while (mem_valid && k < 3000) begin
      tick(1);
      k++;
    end
    check({tag, "_mem_idle"}, 32'(mem_valid), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic       d;
    logic [7:0] rb;
    int         fb, ob;
    wait_mem_idle(tag);
    fb = fetch_log.size();
    ob = oe_cnt;
    flash_csb = 1'b0;
    tick(HALF);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) spi_bit(v.cmd[7-i], 1'b0, d);
    for (int i = 0; i < 24; i++) spi_bit(v.addr[23-i], 1'b0, d);
    for (int i = 0; i < v.ndummy; i++) spi_bit(1'b0, 1'b0, d);
    for (int j = 0; j < v.nbytes; j++) begin
      rb = '0;
      for (int k = 0; k < 8; k++) begin
        spi_bit(1'b0, (j == v.nbytes - 1) && (k == 7), d);
        rb = {rb[6:0], d};
      end
      check($sformatf("%s_byte%0d", tag, j), 32'(rb), 32'(v.exp_bytes[31-8*j -: 8]));
    end
    tick(4);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_oe_off"}, 32'(flash_io1_oe), 32'd0);
    check({tag, "_io1_idle"}, 32'(flash_io1), 32'd1);
    wait_mem_idle(tag);
    check({tag, "_oe_seen"}, 32'(oe_cnt > ob), 32'(v.exp_oe));
    check({tag, "_nfetch"}, 32'(fetch_log.size() - fb), 32'(v.nfetch));
    for (int f = 0; f < v.nfetch; f++)
      if (fb + f < fetch_log.size())
        check($sformatf("%s_fetch%0d", tag, f), 32'(fetch_log[fb+f]), 32'(v.fetches[79-16*f -: 16]));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic       d;
    logic [7:0] c;
    logic [23:0] a;
    logic [3:0] nib;

    for (int i = 0; i < 65536; i++) mem[i] = i[7:0];
    mem[16'h0100] = 8'hDE; mem[16'h0101] = 8'hAD; mem[16'h0102] = 8'hBE; mem[16'h0103] = 8'hEF;
    mem[16'hFFFE] = 8'h12; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h56; mem[16'h0001] = 8'h78;

    vecs[0] = '{cmd: 8'h03, addr: 24'h000100, ndummy: 0, nbytes: 4, exp_bytes: 32'hDEADBEEF, exp_oe: 1'b1,
                nfetch: 5, fetches: {16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104}};
    vecs[1] = '{cmd: 8'h03, addr: 24'h00FFFE, ndummy: 0, nbytes: 4, exp_bytes: 32'h12345678, exp_oe: 1'b1,
                nfetch: 5, fetches: {16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002}};
    vecs[2] = '{cmd: 8'h03, addr: 24'h120005, ndummy: 0, nbytes: 2, exp_bytes: 32'h05060000, exp_oe: 1'b1,
                nfetch: 3, fetches: {16'h0005, 16'h0006, 16'h0007, 32'h0}};
    vecs[3] = '{cmd: 8'hAB, addr: 24'h000100, ndummy: 0, nbytes: 2, exp_bytes: 32'hFFFF0000, exp_oe: 1'b0,
                nfetch: 0, fetches: '0};
    vecs[4] = '{cmd: 8'hFF, addr: 24'h000100, ndummy: 0, nbytes: 2, exp_bytes: 32'hFFFF0000, exp_oe: 1'b0,
                nfetch: 0, fetches: '0};
    vecs[5] = '{cmd: 8'h5A, addr: 24'h000100, ndummy: 0, nbytes: 2, exp_bytes: 32'hFFFF0000, exp_oe: 1'b0,
                nfetch: 0, fetches: '0};
`ifdef SPI_FLASH_RESP_FAST_READ_EN
    vecs[6] = '{cmd: 8'h0B, addr: 24'h000020, ndummy: 8, nbytes: 2, exp_bytes: 32'h20210000, exp_oe: 1'b1,
                nfetch: 3, fetches: {16'h0020, 16'h0021, 16'h0022, 32'h0}};
`else
    vecs[6] = '{cmd: 8'h0B, addr: 24'h000020, ndummy: 8, nbytes: 2, exp_bytes: 32'hFFFF0000, exp_oe: 1'b0,
                nfetch: 0, fetches: '0};
`endif
    vecs[7] = '{cmd: 8'h03, addr: 24'h000010, ndummy: 0, nbytes: 2, exp_bytes: 32'h10110000, exp_oe: 1'b1,
                nfetch: 3, fetches: {16'h0010, 16'h0011, 16'h0012, 32'h0}};

    reset = 1'b1; flash_csb = 1'b1; flash_clk = 1'b0; flash_io0 = 1'b0;
    tick(3);
    check("rst_io1", 32'(flash_io1), 32'd1);
    check("rst_oe", 32'(flash_io1_oe), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    tick(4);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Deselect mid-address, then a clean READ must start from a fresh command.
    wait_mem_idle("abort");
    flash_csb = 1'b0;
    tick(HALF);
    c = 8'h03; a = 24'hABCDEF;
    for (int i = 0; i < 8; i++) spi_bit(c[7-i], 1'b0, d);
    for (int i = 0; i < 13; i++) spi_bit(a[23-i], 1'b0, d);
    tick(HALF);
    flash_csb = 1'b1;
    tick(4);
    check("abort_oe", 32'(flash_io1_oe), 32'd0);
    run_vec(vecs[7], "after_abort");

    // Byte 2 fetch stalls far beyond its slot: 0xFF is sent and underrun sticks.
    slow_en = 1'b1; slow_addr = 16'h0102;
    run_vec('{cmd: 8'h03, addr: 24'h000100, ndummy: 0, nbytes: 3, exp_bytes: 32'hDEADFF00, exp_oe: 1'b1,
              nfetch: 3, fetches: {16'h0100, 16'h0101, 16'h0102, 32'h0}}, "underrun");
    check("underrun_set", 32'(underrun), 32'd1);
    slow_en = 1'b0;
    run_vec(vecs[0], "after_underrun");
    check("underrun_sticky", 32'(underrun), 32'd1);

    // Reset asserted while data is being shifted out.
    flash_csb = 1'b0;
    tick(HALF);
    c = 8'h03; a = 24'h000100; nib = '0;
    for (int i = 0; i < 8; i++) spi_bit(c[7-i], 1'b0, d);
    for (int i = 0; i < 24; i++) spi_bit(a[23-i], 1'b0, d);
    for (int i = 0; i < 4; i++) begin
      spi_bit(1'b0, 1'b0, d);
      nib = {nib[2:0], d};
    end
    check("midrst_nibble", 32'(nib), 32'hD);
    check("midrst_oe_before", 32'(flash_io1_oe), 32'd1);
    reset = 1'b1;
    tick(1);
    check("midrst_oe", 32'(flash_io1_oe), 32'd0);
    check("midrst_io1", 32'(flash_io1), 32'd1);
    check("midrst_mem_valid", 32'(mem_valid), 32'd0);
    check("midrst_underrun", 32'(underrun), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    tick(2);
    reset = 1'b0;
    flash_csb = 1'b1;
    tick(4);
    run_vec(vecs[0], "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
